inst_queue: RTL and testbench

Instruction queue between `inst_fetch` and `inst_decode`. It accepts one fetched instruction per cycle, with its virtual address and fetch-address exception bits, and holds it in a DEPTH-entry circular FIFO. It presents the oldest entry to decode with a valid/ready handshake, so icache hits can keep flowing while decode stalls. A flush on exception or taken branch discards all queued entries in one cycle.

---
 rtl/inst_queue.sv | 145 ++++++++++++++
 tb/tb_inst_queue.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// inst_queue: instruction queue between inst_fetch and inst_decode.
//
// Holds up to DEPTH fetched entries {vaddr, inst, ex} in a circular FIFO and
// presents the oldest one to decode.  A flush empties the queue in one cycle.
//
// Optional feature macro: INST_QUEUE_BYPASS_EN
//   When defined, an entry pushed into an empty queue is visible to decode in
//   the same cycle.  If decode takes it, the entry is never written.
//
// Ports:
//   clk       clock, all state on the rising edge
//   rst       asynchronous active-low reset
//   flush     discard all entries (exception or taken branch)
//   if_valid  fetch offers an entry this cycle
//   if_vaddr  PC of the offered instruction
//   if_inst   instruction word from the icache
//   if_ex     fetch-address exceptions {illegal, miss, invalid}
//   ready_o   queue can accept a push this cycle
//   id_valid  head entry valid toward decode
//   id_vaddr  head PC
//   id_inst   head instruction (32'h0 when id_ex is nonzero)
//   id_ex     head exception bits
//   id_ready  decode accepts the head this cycle
//   count     current occupancy
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high.  On the fetch side the offer is taken when if_valid & ready_o &
// ~flush; ready_o depends only on registered occupancy, so a pop in the same
// cycle does not open a slot for a push.  On the decode side the head is
// consumed when id_valid & id_ready; id_ready is ignored while id_valid is 0.
module inst_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       if_valid,
  input  logic [ADDR_W-1:0]          if_vaddr,
  input  logic [31:0]                if_inst,
  input  logic [2:0]                 if_ex,
  output logic                       ready_o,
  output logic                       id_valid,
  output logic [ADDR_W-1:0]          id_vaddr,
  output logic [31:0]                id_inst,
  output logic [2:0]                 id_ex,
  input  logic                       id_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] mem_vaddr [DEPTH];
  logic [31:0]       mem_inst  [DEPTH];
  logic [2:0]        mem_ex    [DEPTH];

  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_nxt;

  logic        push;
  logic        pop;
  logic        wr;
  logic        q_valid;
  logic [31:0] if_inst_gated;

  // Faulting fetches are stored as NOPs; the ex bits carry the fault.
  assign if_inst_gated = (if_ex != 3'b000) ? 32'h0 : if_inst;

  assign ready_o = (count_q != FULL);
  assign push    = if_valid & ready_o & ~flush;
  assign q_valid = (count_q != '0) & ~flush;
  assign pop     = q_valid & id_ready;
  assign count   = count_q;

`ifdef INST_QUEUE_BYPASS_EN
  logic byp;
  logic byp_take;

  assign byp      = push & (count_q == '0);
  assign byp_take = byp & id_ready;
  // A bypassed entry taken by decode is never written.
  assign wr       = push & ~byp_take;

  always_comb begin
    id_valid = q_valid | byp;
    id_vaddr = mem_vaddr[rptr];
    id_inst  = mem_inst[rptr];
    id_ex    = mem_ex[rptr];
    if (byp) begin
      id_vaddr = if_vaddr;
      id_inst  = if_inst_gated;
      id_ex    = if_ex;
    end
  end
`else
  assign wr       = push;
  assign id_valid = q_valid;
  assign id_vaddr = mem_vaddr[rptr];
  assign id_inst  = mem_inst[rptr];
  assign id_ex    = mem_ex[rptr];
`endif

  always_comb begin
    count_nxt = count_q;
    case ({wr, pop})
      2'b10:   count_nxt = count_q + CNT_W'(1);
      2'b01:   count_nxt = count_q - CNT_W'(1);
      default: count_nxt = count_q;
    endcase
  end

  // Storage is cleared on reset so the head reads as zero until a push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr    <= '0;
      wptr    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_vaddr[i] <= '0;
        mem_inst[i]  <= '0;
        mem_ex[i]    <= '0;
      end
    end else if (flush) begin
      rptr    <= '0;
      wptr    <= '0;
      count_q <= '0;
    end else begin
      if (wr) begin
        mem_vaddr[wptr] <= if_vaddr;
        mem_inst[wptr]  <= if_inst_gated;
        mem_ex[wptr]    <= if_ex;
        wptr            <= wptr + PTR_W'(1);
      end
      if (pop) begin
        rptr <= rptr + PTR_W'(1);
      end
      count_q <= count_nxt;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed bench for inst_queue with a scoreboard.
// The driver applies one cycle of inputs per step and pushes the expected
// head entry into exp_q when the push should be accepted; the monitor checks
// the handshake outputs every cycle and pops exp_q on every decode transfer.
module tb_inst_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int W      = ADDR_W + 35;

  logic                 clk;
  logic                 rst;
  logic                 flush;
  logic                 if_valid;
  logic [ADDR_W-1:0]    if_vaddr;
  logic [31:0]          if_inst;
  logic [2:0]           if_ex;
  logic                 ready_o;
  logic                 id_valid;
  logic [ADDR_W-1:0]    id_vaddr;
  logic [31:0]          id_inst;
  logic [2:0]           id_ex;
  logic                 id_ready;
  logic [$clog2(DEPTH):0] count;

  inst_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .if_valid (if_valid),
    .if_vaddr (if_vaddr),
    .if_inst  (if_inst),
    .if_ex    (if_ex),
    .ready_o  (ready_o),
    .id_valid (id_valid),
    .id_vaddr (id_vaddr),
    .id_inst  (id_inst),
    .id_ex    (id_ex),
    .id_ready (id_ready),
    .count    (count)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic mon_en  = 1'b0;
  logic exp_valid;
  logic exp_ready;
  int   exp_cnt;
  int   mcount;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      check("id_valid", W'(id_valid), W'(exp_valid));
      check("ready_o",  W'(ready_o),  W'(exp_ready));
      check("count",    W'(count),    W'(exp_cnt));
      if (id_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pop: got vaddr %h with no entry expected (t=%0t)", id_vaddr, $time);
        end else begin
          check("head_entry", {id_vaddr, id_inst, id_ex}, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver ----------------
  // One cycle of stimulus plus the expected behaviour for that cycle.
  task automatic step(input logic v, input logic [ADDR_W-1:0] va, input logic [31:0] in,
                      input logic [2:0] ex, input logic rdy, input logic fl);
    logic m_push, m_pop, m_take;
    @(posedge clk);
    #1;
    if_valid = v;
    if_vaddr = va;
    if_inst  = in;
    if_ex    = ex;
    id_ready = rdy;
    flush    = fl;
    m_push    = v && (mcount != DEPTH) && !fl;
    m_pop     = (mcount != 0) && !fl && rdy;
    m_take    = 1'b0;
    exp_valid = (mcount != 0) && !fl;
    exp_ready = (mcount != DEPTH);
    exp_cnt   = mcount;
`ifdef INST_QUEUE_BYPASS_EN
    if (m_push && mcount == 0) begin
      exp_valid = 1'b1;
      m_take    = rdy;
    end
`endif
    if (fl) begin
      exp_q.delete();
      mcount = 0;
    end else begin
      if (m_push) exp_q.push_back({va, (ex != 3'b000) ? 32'h0 : in, ex});
      mcount = mcount + ((m_push && !m_take) ? 1 : 0) - (m_pop ? 1 : 0);
    end
    mon_en = 1'b1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, '0, '0, 3'b000, rdy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_id_valid"}, W'(id_valid), W'(0));
    check({tag, "_ready_o"},  W'(ready_o),  W'(1));
    check({tag, "_count"},    W'(count),    W'(0));
    check({tag, "_head"},     {id_vaddr, id_inst, id_ex}, W'(0));
  endtask

  // Leaves the model matching a just-released, empty queue.
  task automatic release_reset();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    mcount    = 0;
    exp_valid = 1'b0;
    exp_ready = 1'b1;
    exp_cnt   = 0;
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; flush = 1'b0; if_valid = 1'b0; if_vaddr = '0;
    if_inst = '0; if_ex = '0; id_ready = 1'b0;
    mcount = 0; exp_valid = 1'b0; exp_ready = 1'b1; exp_cnt = 0;

    // reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset_outputs("reset");
    end
    release_reset();

    // first push after reset, visible next cycle
    step(1'b1, 32'hbfc00000, 32'h24080001, 3'b000, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // fill to DEPTH with decode stalled, then offer a fifth
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 32'h00000100 + 32'(4 * i), 32'h20000000 + 32'(i), 3'b000, 1'b0, 1'b0);
    step(1'b1, 32'h00000110, 32'h20000004, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) idle(1'b1);
    idle(1'b0);

    // wrap-around: one entry queued, then push+pop every cycle
    step(1'b1, 32'h00000200, 32'h30000000, 3'b000, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++)
      step(1'b1, 32'h00000200 + 32'(4 * i), 32'h30000000 + 32'(i), 3'b000, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // flush with 3 queued and a simultaneous push
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h00000300 + 32'(4 * i), 32'h40000000 + 32'(i), 3'b000, 1'b0, 1'b0);
    step(1'b1, 32'h0000030c, 32'h4000000c, 3'b000, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // exception entry: inst forced to NOP, ex passed through
    step(1'b1, 32'h00000400, 32'hdeadbeef, 3'b100, 1'b0, 1'b0);
    idle(1'b1);
    step(1'b1, 32'h00000404, 32'hcafef00d, 3'b001, 1'b1, 1'b0);
    idle(1'b1);

    // from empty with decode ready (0-cycle with bypass, 1-cycle without)
    step(1'b1, 32'h00000500, 32'h50000000, 3'b000, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // reset asserted mid-operation drops queued entries
    step(1'b1, 32'h00000600, 32'h60000000, 3'b000, 1'b0, 1'b0);
    step(1'b1, 32'h00000604, 32'h60000001, 3'b000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    if_valid = 1'b0;
    id_ready = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    release_reset();
    idle(1'b1);
    step(1'b1, 32'h00000700, 32'h70000000, 3'b000, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b0);

    @(posedge clk);
    #1;
    mon_en = 1'b0;
    check("drained", W'(exp_q.size()), W'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
